// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the control unit and its helpers:
//   - one-hot control-state bit positions and the Io state constant
//   - I/O direction encodings
//   - state encoding of the I/O port unit FSM
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int unsigned STATE_W = 9;

    // Bit positions in the one-hot control state vector
    localparam int unsigned STATE_FETCH_BIT  = 0;
    localparam int unsigned STATE_DECODE_BIT = 1;
    localparam int unsigned STATE_EXEC_BIT   = 2;
    localparam int unsigned STATE_MEM_BIT    = 3;
    localparam int unsigned STATE_WB_BIT     = 4;
    localparam int unsigned STATE_BRANCH_BIT = 5;
    localparam int unsigned STATE_IO_BIT     = 6;
    localparam int unsigned STATE_INCPC_BIT  = 7;
    localparam int unsigned STATE_HALT_BIT   = 8;

    localparam logic [STATE_W-1:0] STATE_IO    = 9'b0_0100_0000;
    localparam logic [STATE_W-1:0] STATE_INCPC = 9'b0_1000_0000;

    // I/O direction
    localparam logic IO_DIR_IN  = 1'b0;
    localparam logic IO_DIR_OUT = 1'b1;

    // I/O port unit FSM
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } io_state_e;

endpackage

// File: rtl/io_timeout_counter.sv
// -----------------------------------------------------------------------------
// io_timeout_counter
// Counts bus-request cycles without acknowledge for the I/O port unit.
// Only instantiated when IO_PORT_UNIT_TIMEOUT_EN is defined.
//   i_clk  : system clock, rising edge
//   i_rst  : asynchronous active-high reset
//   i_clr  : synchronous clear (entry to the request state)
//   i_en   : count this cycle (request pending, no ack)
//   o_tc   : terminal count; high in the cycle whose increment reaches LIMIT
// -----------------------------------------------------------------------------
module io_timeout_counter #(
    parameter int unsigned LIMIT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    // A zero limit behaves as a limit of one
    localparam int unsigned LimEff = (LIMIT == 0) ? 1 : LIMIT;
    localparam int unsigned CntW   = $clog2(LimEff + 1);

    logic [CntW-1:0] r_cnt;

    // Fires while LIMIT-1 unacknowledged cycles have already been counted,
    // so the LIMIT-th waiting cycle is the last one.
    assign o_tc = i_en && (r_cnt == CntW'(LimEff - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc) begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

endmodule

// File: rtl/io_port_unit.sv
// -----------------------------------------------------------------------------
// io_port_unit
// Executes IN/OUT instructions during the control FSM's Io state: one
// req/ack transaction on the peripheral bus, then a one-cycle io_done pulse.
//
// Optional feature macro: IO_PORT_UNIT_TIMEOUT_EN
//   defined   : request aborts after TIMEOUT cycles without ack, sets sticky
//               o_io_err, reads return 0, io_done still pulses
//   undefined : request waits for ack indefinitely, o_io_err tied 0
//
// Ports:
//   i_clk, i_rst      : clock (rising edge), asynchronous active-high reset
//   i_state           : one-hot control state, bit STATE_IO_BIT = Io
//   i_io_dir          : 0 = IN, 1 = OUT
//   i_io_port         : target port address
//   i_io_wdata        : OUT operand
//   o_io_done         : one-cycle completion pulse
//   o_io_rdata        : data from the last IN
//   o_io_err          : sticky timeout flag
//   o_bus_req/we/addr/wdata : peripheral bus request side (registered)
//   i_bus_rdata/ack   : peripheral bus response side
// -----------------------------------------------------------------------------
module io_port_unit
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PORT_W  = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [STATE_W-1:0] i_state,
    input  logic               i_io_dir,
    input  logic [PORT_W-1:0]  i_io_port,
    input  logic [DATA_W-1:0]  i_io_wdata,
    output logic               o_io_done,
    output logic [DATA_W-1:0]  o_io_rdata,
    output logic               o_io_err,
    output logic               o_bus_req,
    output logic               o_bus_we,
    output logic [PORT_W-1:0]  o_bus_addr,
    output logic [DATA_W-1:0]  o_bus_wdata,
    input  logic [DATA_W-1:0]  i_bus_rdata,
    input  logic               i_bus_ack
);

    io_state_e          r_state;
    io_state_e          w_state_next;
    logic               r_io_q;
    logic               w_start;
    logic               w_launch;
    logic               w_ack_done;
    logic               w_timeout;
    logic               w_to_done;
    logic               r_io_done;
    logic               r_bus_req;
    logic               r_bus_we;
    logic [PORT_W-1:0]  r_bus_addr;
    logic [DATA_W-1:0]  r_bus_wdata;
    logic [DATA_W-1:0]  r_io_rdata;

    // Only the Io bit of the control state matters here
    logic w_unused_state;
    assign w_unused_state = ^(i_state & ~STATE_IO);

    // Rising edge of Io: re-entry requires Io to drop for a cycle
    assign w_start    = i_state[STATE_IO_BIT] && !r_io_q;
    assign w_launch   = (r_state == StIdle) && w_start;
    assign w_ack_done = (r_state == StReq) && i_bus_ack;
    // Ack in the timeout cycle takes priority
    assign w_to_done  = (r_state == StReq) && !i_bus_ack && w_timeout;

`ifdef IO_PORT_UNIT_TIMEOUT_EN
    logic r_io_err;

    io_timeout_counter #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_launch),
        .i_en  ((r_state == StReq) && !i_bus_ack),
        .o_tc  (w_timeout)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_io_err <= 1'b0;
        end else if (w_to_done) begin
            r_io_err <= 1'b1;
        end
    end

    assign o_io_err = r_io_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
    assign w_timeout        = 1'b0;
    assign o_io_err         = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_start) w_state_next = StReq;
            StReq:   if (i_bus_ack || w_timeout) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_io_q  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_io_q  <= i_state[STATE_IO_BIT];
        end
    end

    // Outputs registered from the next state so bus_ack never reaches
    // io_done combinationally.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bus_req   <= 1'b0;
            r_io_done   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_io_rdata  <= '0;
        end else begin
            r_bus_req <= (w_state_next == StReq);
            r_io_done <= (w_state_next == StDone);
            if (w_launch) begin
                r_bus_we    <= i_io_dir;
                r_bus_addr  <= i_io_port;
                r_bus_wdata <= i_io_wdata;
            end
            if (w_ack_done && (r_bus_we == IO_DIR_IN)) begin
                r_io_rdata <= i_bus_rdata;
            end else if (w_to_done && (r_bus_we == IO_DIR_IN)) begin
                r_io_rdata <= '0;
            end
        end
    end

    assign o_io_done   = r_io_done;
    assign o_bus_req   = r_bus_req;
    assign o_bus_we    = r_bus_we;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_wdata = r_bus_wdata;
    assign o_io_rdata  = r_io_rdata;

endmodule

// File: tb/tb_io_port_unit.sv
// Testbench for io_port_unit. Inputs change on the falling edge, outputs are
// sampled on the falling edge. Expected read data is queued when a
// transaction starts and popped when io_done appears.
module tb_io_port_unit;
    import cpu_pkg::*;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned PORT_W  = 4;
    localparam int unsigned TIMEOUT = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [STATE_W-1:0] state;
    logic               io_dir;
    logic [PORT_W-1:0]  io_port;
    logic [DATA_W-1:0]  io_wdata;
    logic               io_done;
    logic [DATA_W-1:0]  io_rdata;
    logic               io_err;
    logic               bus_req;
    logic               bus_we;
    logic [PORT_W-1:0]  bus_addr;
    logic [DATA_W-1:0]  bus_wdata;
    logic [DATA_W-1:0]  bus_rdata;
    logic               bus_ack;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] m_rdata;
    logic [DATA_W-1:0] sb_q[$];
    logic [DATA_W-1:0] exp_rd;
    logic              e_req;
    logic              e_done;
    logic              e_err;

    always #5 clk = ~clk;

    io_port_unit #(
        .DATA_W  (DATA_W),
        .PORT_W  (PORT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_state     (state),
        .i_io_dir    (io_dir),
        .i_io_port   (io_port),
        .i_io_wdata  (io_wdata),
        .o_io_done   (io_done),
        .o_io_rdata  (io_rdata),
        .o_io_err    (io_err),
        .o_bus_req   (bus_req),
        .o_bus_we    (bus_we),
        .o_bus_addr  (bus_addr),
        .o_bus_wdata (bus_wdata),
        .i_bus_rdata (bus_rdata),
        .i_bus_ack   (bus_ack)
    );

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        rst = 1'b1; state = '0; io_dir = 1'b0; io_port = '0; io_wdata = '0;
        bus_rdata = 8'h77; bus_ack = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus_req, io_done, bus_we, io_err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0000", {bus_req, io_done, bus_we, io_err});
        end
        checks++;
        if ({bus_addr, bus_wdata, io_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {bus_addr, bus_wdata, io_rdata});
        end
        rst = 1'b0;
        m_rdata = '0;
        sb_q.delete();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus_req, io_done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=00", {bus_req, io_done});
        end
    endtask

    // OUT to port 3, ack in cycle 3
    task automatic test_out_write;
        @(negedge clk);
        state = STATE_IO; io_dir = IO_DIR_OUT; io_port = 4'h3; io_wdata = 8'hA5;
        sb_q.push_back(m_rdata);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            e_req  = (c >= 1 && c <= 3);
            e_done = (c == 4);
            checks++;
            if (bus_req !== e_req) begin
                failures++;
                $display("FAIL out_req c=%0d got=%b exp=%b", c, bus_req, e_req);
            end
            if (c <= 3) begin
                checks++;
                if ({bus_we, bus_addr, bus_wdata} !== {1'b1, 4'h3, 8'hA5}) begin
                    failures++;
                    $display("FAIL out_bus c=%0d got=%h exp=%h", c,
                             {bus_we, bus_addr, bus_wdata}, {1'b1, 4'h3, 8'hA5});
                end
            end
            checks++;
            if (io_done !== e_done) begin
                failures++;
                $display("FAIL out_done c=%0d got=%b exp=%b", c, io_done, e_done);
            end
            if (io_done === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL out_sb got=extra_done exp=none");
                end else begin
                    exp_rd = sb_q.pop_front();
                    if (io_rdata !== exp_rd) begin
                        failures++;
                        $display("FAIL out_rdata got=%h exp=%h", io_rdata, exp_rd);
                    end
                end
            end
            // Operands must stay latched even if the datapath moves on
            if (c == 1) begin
                io_wdata = 8'hFF; io_port = 4'hF; io_dir = IO_DIR_IN;
            end
            bus_ack = (c == 3);
            if (c == 4) state = '0;
        end
    endtask

    // IN from port C, ack in cycle 1
    task automatic test_in_read;
        @(negedge clk);
        state = STATE_IO; io_dir = IO_DIR_IN; io_port = 4'hC; io_wdata = 8'h11;
        m_rdata = 8'h5E;
        sb_q.push_back(m_rdata);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            e_req  = (c == 1);
            e_done = (c == 2);
            checks++;
            if ({bus_req, io_done} !== {e_req, e_done}) begin
                failures++;
                $display("FAIL in_ctrl c=%0d got=%b exp=%b", c, {bus_req, io_done}, {e_req, e_done});
            end
            if (c == 1) begin
                checks++;
                if ({bus_we, bus_addr} !== {1'b0, 4'hC}) begin
                    failures++;
                    $display("FAIL in_bus got=%h exp=%h", {bus_we, bus_addr}, {1'b0, 4'hC});
                end
            end
            if (io_done === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL in_sb got=extra_done exp=none");
                end else begin
                    exp_rd = sb_q.pop_front();
                    if (io_rdata !== exp_rd) begin
                        failures++;
                        $display("FAIL in_rdata got=%h exp=%h", io_rdata, exp_rd);
                    end
                end
            end
            bus_ack   = (c == 1);
            bus_rdata = (c == 1) ? 8'h5E : 8'h77;
            if (c == 2) state = '0;
        end
        checks++;
        if (io_err !== 1'b0) begin
            failures++;
            $display("FAIL in_err got=%b exp=0", io_err);
        end
    endtask

    // OUT straight after the IN; read data must survive it
    task automatic test_back_to_back;
        @(negedge clk);
        state = STATE_IO; io_dir = IO_DIR_OUT; io_port = 4'h7; io_wdata = 8'h3C;
        sb_q.push_back(m_rdata);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            e_req  = (c <= 2);
            e_done = (c == 3);
            checks++;
            if ({bus_req, io_done} !== {e_req, e_done}) begin
                failures++;
                $display("FAIL b2b_ctrl c=%0d got=%b exp=%b", c, {bus_req, io_done}, {e_req, e_done});
            end
            if (c <= 2) begin
                checks++;
                if ({bus_we, bus_addr, bus_wdata} !== {1'b1, 4'h7, 8'h3C}) begin
                    failures++;
                    $display("FAIL b2b_bus c=%0d got=%h exp=%h", c,
                             {bus_we, bus_addr, bus_wdata}, {1'b1, 4'h7, 8'h3C});
                end
            end
            if (io_done === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_sb got=extra_done exp=none");
                end else begin
                    exp_rd = sb_q.pop_front();
                    if (io_rdata !== exp_rd) begin
                        failures++;
                        $display("FAIL b2b_rdata got=%h exp=%h", io_rdata, exp_rd);
                    end
                end
            end
            bus_ack   = (c == 2);
            bus_rdata = (c == 2) ? 8'hC3 : 8'h77;
            if (c == 3) state = '0;
        end
        checks++;
        if (io_rdata !== 8'h5E) begin
            failures++;
            $display("FAIL b2b_hold got=%h exp=5e", io_rdata);
        end
    endtask

    // Ack while idle is ignored; holding Io high does not restart
    task automatic test_spurious_reentry;
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 8'h99;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if ({bus_req, io_done, io_rdata} !== {2'b00, m_rdata}) begin
                failures++;
                $display("FAIL spur c=%0d got=%h exp=%h", c, {bus_req, io_done, io_rdata},
                         {2'b00, m_rdata});
            end
            if (c == 2) bus_ack = 1'b0;
        end
        bus_rdata = 8'h77;
        state = STATE_IO; io_dir = IO_DIR_OUT; io_port = 4'h5; io_wdata = 8'h5A;
        sb_q.push_back(m_rdata);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            e_req  = (c == 1);
            e_done = (c == 2);
            checks++;
            if ({bus_req, io_done} !== {e_req, e_done}) begin
                failures++;
                $display("FAIL reent_ctrl c=%0d got=%b exp=%b", c, {bus_req, io_done}, {e_req, e_done});
            end
            if (io_done === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL reent_sb got=extra_done exp=none");
                end else begin
                    exp_rd = sb_q.pop_front();
                    if (io_rdata !== exp_rd) begin
                        failures++;
                        $display("FAIL reent_rdata got=%h exp=%h", io_rdata, exp_rd);
                    end
                end
            end
            bus_ack = (c == 1);
            if (c == 5) state = '0;
        end
    endtask

    // Reset inside REQ, then a normal IN
    task automatic test_async_reset;
        @(negedge clk);
        state = STATE_IO; io_dir = IO_DIR_OUT; io_port = 4'h2; io_wdata = 8'h42;
        sb_q.push_back(m_rdata);
        repeat (2) @(negedge clk);
        checks++;
        if (bus_req !== 1'b1) begin
            failures++;
            $display("FAIL arst_pre got=%b exp=1", bus_req);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus_req, io_done} !== 2'b00) begin
            failures++;
            $display("FAIL arst_drop got=%b exp=00", {bus_req, io_done});
        end
        @(negedge clk);
        state = '0;
        rst = 1'b0;
        sb_q.delete();
        m_rdata = '0;
        @(negedge clk);
        checks++;
        if ({bus_req, io_done, io_rdata} !== {2'b00, 8'h00}) begin
            failures++;
            $display("FAIL arst_post got=%h exp=0", {bus_req, io_done, io_rdata});
        end
        state = STATE_IO; io_dir = IO_DIR_IN; io_port = 4'h9;
        m_rdata = 8'hA7;
        sb_q.push_back(m_rdata);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            e_req  = (c <= 2);
            e_done = (c == 3);
            checks++;
            if ({bus_req, io_done} !== {e_req, e_done}) begin
                failures++;
                $display("FAIL arst_txn c=%0d got=%b exp=%b", c, {bus_req, io_done}, {e_req, e_done});
            end
            if (io_done === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL arst_sb got=extra_done exp=none");
                end else begin
                    exp_rd = sb_q.pop_front();
                    if (io_rdata !== exp_rd) begin
                        failures++;
                        $display("FAIL arst_rdata got=%h exp=%h", io_rdata, exp_rd);
                    end
                end
            end
            bus_ack   = (c == 2);
            bus_rdata = (c == 2) ? 8'hA7 : 8'h77;
            if (c == 3) state = '0;
        end
    endtask

`ifdef IO_PORT_UNIT_TIMEOUT_EN
    // Ack on the last allowed cycle completes normally; no ack times out
    task automatic test_timeout;
        for (int run = 0; run < 2; run++) begin
            @(negedge clk);
            state = STATE_IO; io_dir = IO_DIR_IN; io_port = 4'h1;
            m_rdata = (run == 0) ? 8'h3D : 8'h00;
            sb_q.push_back(m_rdata);
            for (int c = 1; c <= 7; c++) begin
                @(negedge clk);
                e_req  = (c <= 4);
                e_done = (c == 5);
                e_err  = (run == 1) && (c >= 5);
                checks++;
                if ({bus_req, io_done, io_err} !== {e_req, e_done, e_err}) begin
                    failures++;
                    $display("FAIL to%0d_ctrl c=%0d got=%b exp=%b", run, c,
                             {bus_req, io_done, io_err}, {e_req, e_done, e_err});
                end
                if (io_done === 1'b1) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        failures++;
                        $display("FAIL to%0d_sb got=extra_done exp=none", run);
                    end else begin
                        exp_rd = sb_q.pop_front();
                        if (io_rdata !== exp_rd) begin
                            failures++;
                            $display("FAIL to%0d_rdata got=%h exp=%h", run, io_rdata, exp_rd);
                        end
                    end
                end
                bus_ack   = (run == 0) && (c == 4);
                bus_rdata = bus_ack ? 8'h3D : 8'h77;
                if (c == 5) state = '0;
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_out_write();
        test_in_read();
        test_back_to_back();
        test_spurious_reentry();
        test_async_reset();
`ifdef IO_PORT_UNIT_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got=%0d exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
